// File: rtl/spi_reg_bank.sv
// SPI mode-0 target owning NUM_REGS x DATA_W configuration registers with read-back on CIPO.
// Frames are R/W, address, data (MSB first); a write commits on CS rise only if exactly FRAME_W bits arrived.
module spi_reg_bank #(
    parameter int NUM_REGS = 5,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       spi_sclk,
    input  logic                       spi_copi,
    input  logic                       spi_cs,
    output logic                       spi_cipo,
    output logic                       spi_cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_pulse,
    output logic [ADDR_W-1:0]          wr_addr
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // [0] metastability flop, [1] synchronised value, [2] history for edge detection
    logic [2:0] sclk_pipe_q, sclk_pipe_d;
    logic [2:0] copi_pipe_q, copi_pipe_d;
    logic [2:0] cs_pipe_q,   cs_pipe_d;

    logic [0:0]         state_q,    state_d;
    logic [CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [FRAME_W-1:0] rx_q,       rx_d;
    logic [DATA_W-1:0]  tx_q,       tx_d;
    logic               is_read_q,  is_read_d;
    logic               cipo_q,     cipo_d;
    logic               cipo_oe_q,  cipo_oe_d;
    logic               wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0]  wr_addr_q,  wr_addr_d;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic [DATA_W-1:0]  regs_d [NUM_REGS];

    logic               sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [FRAME_W-1:0] rx_shift;
    logic [ADDR_W-1:0]  setup_addr;
    logic [ADDR_W-1:0]  frame_addr;
    logic [DATA_W-1:0]  frame_data;
    logic [DATA_W-1:0]  rd_word;
    logic               commit_ok;

    always_comb begin
        sclk_pipe_d = {sclk_pipe_q[1:0], spi_sclk};
        copi_pipe_d = {copi_pipe_q[1:0], spi_copi};
        cs_pipe_d   = {cs_pipe_q[1:0],   spi_cs};
    end

    assign sclk_rise = sclk_pipe_q[1] & ~sclk_pipe_q[2];
    assign sclk_fall = ~sclk_pipe_q[1] & sclk_pipe_q[2];
    assign cs_rise   = cs_pipe_q[1] & ~cs_pipe_q[2];
    assign cs_fall   = ~cs_pipe_q[1] & cs_pipe_q[2];

    assign rx_shift   = {rx_q[FRAME_W-2:0], copi_pipe_q[1]};
    assign setup_addr = rx_shift[ADDR_W-1:0];
    assign frame_addr = rx_q[DATA_W +: ADDR_W];
    assign frame_data = rx_q[DATA_W-1:0];
    assign commit_ok  = (bit_cnt_q == CNT_FULL) && rx_q[FRAME_W-1]
                        && (32'(frame_addr) < NUM_REGS);

    // Out-of-range read addresses match no register and return zero.
    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(setup_addr) == i) rd_word = regs_q[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        is_read_d  = is_read_q;
        cipo_d     = cipo_q;
        cipo_oe_d  = cipo_oe_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        regs_d     = regs_q;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                    tx_d      = '0;
                    is_read_d = 1'b0;
                    cipo_d    = 1'b0;
                    cipo_oe_d = 1'b0;
                end
            end
            ST_ACTIVE: begin
                // A CS rise takes priority: any SCLK edge seen in the same cycle is dropped.
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    is_read_d = 1'b0;
                    cipo_d    = 1'b0;
                    cipo_oe_d = 1'b0;
                    if (commit_ok) begin
                        for (int unsigned i = 0; i < NUM_REGS; i++) begin
                            if (32'(frame_addr) == i) regs_d[i] = frame_data;
                        end
                        wr_addr_d  = frame_addr;
                        wr_pulse_d = 1'b1;
                    end
                end else begin
                    if (sclk_rise) begin
                        rx_d = rx_shift;
                        if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == CNT_ADDR && !rx_shift[ADDR_W]) begin
                            is_read_d = 1'b1;
                            tx_d      = rd_word;
                        end
                    end
                    if (sclk_fall && is_read_q) begin
                        cipo_d    = tx_q[DATA_W-1];
                        tx_d      = tx_q << 1;
                        cipo_oe_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // CS synchroniser resets low so a CS already held low after reset is not seen as a fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_pipe_q <= '0;
            copi_pipe_q <= '0;
            cs_pipe_q   <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            is_read_q   <= 1'b0;
            cipo_q      <= 1'b0;
            cipo_oe_q   <= 1'b0;
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= '0;
            regs_q      <= '{default: '0};
        end else begin
            sclk_pipe_q <= sclk_pipe_d;
            copi_pipe_q <= copi_pipe_d;
            cs_pipe_q   <= cs_pipe_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            is_read_q   <= is_read_d;
            cipo_q      <= cipo_d;
            cipo_oe_q   <= cipo_oe_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_addr_q   <= wr_addr_d;
            regs_q      <= regs_d;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    assign spi_cipo    = cipo_q;
    assign spi_cipo_oe = cipo_oe_q;
    assign wr_pulse    = wr_pulse_q;
    assign wr_addr     = wr_addr_q;

endmodule
